// File: rtl/input_event_scheduler_if.sv
// Host-event and processor-request bundle for input_event_scheduler.
// slave modport: scheduler side; master modport: host/processor side.
// Widths default to 14-bit row index, 16-bit time, 16-entry queue count.
interface input_event_scheduler_if #(
  parameter int TW = 16,
  parameter int IW = 14,
  parameter int CW = 5
);
  logic          ev_valid;
  logic          ev_ready;
  logic [TW-1:0] ev_time;
  logic [IW-1:0] ev_index;
  logic [TW-1:0] network_time;
  logic          input_occurred;
  logic [IW-1:0] input_index;
  logic          input_ack;
  logic [CW-1:0] fifo_count;
  logic [15:0]   late_count;

  modport slave (
    input  ev_valid, ev_time, ev_index, network_time, input_ack,
    output ev_ready, input_occurred, input_index, fifo_count, late_count
  );

  modport master (
    output ev_valid, ev_time, ev_index, network_time, input_ack,
    input  ev_ready, input_occurred, input_index, fifo_count, late_count
  );
endinterface

// File: rtl/input_event_scheduler.sv
// Timestamped spike queue: releases head event to network_processor once due.
// Latency: push-to-request 2 cycles; due-to-request 1 cycle; ack-to-drop 1 cycle.
// Backpressure: ev_ready low while queue full; request held until input_ack.
module input_event_scheduler #(
  parameter int SR_DEPTH         = 16384,
  parameter int MAX_NETWORK_TIME = 65536,
  parameter int FIFO_DEPTH       = 16
) (
  input logic                    clk,
  input logic                    reset,
  input_event_scheduler_if.slave bus
);
  localparam int IW = $clog2(SR_DEPTH);
  localparam int TW = $clog2(MAX_NETWORK_TIME);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [TW-1:0] time_mem_q  [FIFO_DEPTH];
  logic [IW-1:0] index_mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   late_q, late_d;

  logic          push, pop;
  logic [TW-1:0] head_time;
  logic [IW-1:0] head_index;
  logic [TW-1:0] head_delta;
  logic          head_due;

  // Full check uses only the registered count, so a same-cycle pop never frees a slot early.
  assign push       = bus.ev_valid && (count_q != FULL_CNT);
  assign head_time  = time_mem_q[rd_ptr_q];
  assign head_index = index_mem_q[rd_ptr_q];
  // Modular difference keeps the due test correct across the time wrap:
  // the head is due if it lies within the last half of the time circle.
  assign head_delta = bus.network_time - head_time;
  assign head_due   = (count_q != '0) && !head_delta[TW-1];

  // Queue storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      time_mem_q[wr_ptr_q]  <= bus.ev_time;
      index_mem_q[wr_ptr_q] <= bus.ev_index;
    end
  end

  // Next-state, presented index and late counter; pop only on an ack while presenting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    late_d  = late_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_due) begin
          idx_d   = head_index;
          state_d = PRESENT;
          if ((head_delta != '0) && (late_q != 16'hFFFF)) begin
            late_d = late_q + 16'd1;
          end
        end
      end
      PRESENT: begin
        if (bus.input_ack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy: simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any presented or queued events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      late_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      late_q  <= late_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign bus.ev_ready       = (count_q != FULL_CNT);
  assign bus.input_occurred = (state_q == PRESENT);
  assign bus.input_index    = idx_q;
  assign bus.fifo_count     = count_q;
  assign bus.late_count     = late_q;
endmodule

// File: tb/tb_input_event_scheduler.sv
// Bench for input_event_scheduler: vector table, directed corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_input_event_scheduler;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  input_event_scheduler_if #(.TW(16), .IW(14), .CW(5)) bus ();

  input_event_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending events in arrival order plus presentation status.
  typedef struct {
    logic [15:0] t;
    logic [13:0] i;
  } ev_t;
  ev_t         mq[$];
  bit          m_pres;
  logic [13:0] m_idx;
  logic [15:0] m_late;

  typedef struct {
    bit          v;
    logic [15:0] t;
    logic [13:0] i;
    logic [15:0] nt;
    bit          ack;
    bit          eo;
    logic [13:0] eidx;
    int          ecnt;
    int          elate;
    bit          erdy;
  } vec_t;
  vec_t tbl[7];

  task automatic model_reset();
    mq.delete();
    m_pres = 1'b0;
    m_idx  = '0;
    m_late = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit eo, input logic [13:0] eidx,
                           input int ecnt, input int elate, input bit erdy);
    chk({tag, ".occ"}, 32'(bus.input_occurred), 32'(eo));
    chk({tag, ".idx"}, 32'(bus.input_index), 32'(eidx));
    chk({tag, ".cnt"}, 32'(bus.fifo_count), 32'(ecnt));
    chk({tag, ".late"}, 32'(bus.late_count), 32'(elate));
    chk({tag, ".rdy"}, 32'(bus.ev_ready), 32'(erdy));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_pres, m_idx, mq.size(), int'(m_late), mq.size() < 16);
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [15:0] t, input logic [13:0] i,
                      input logic [15:0] nt, input bit ack);
    ev_t         e;
    bit          psh;
    logic [15:0] d;
    bus.ev_valid     = v;
    bus.ev_time      = t;
    bus.ev_index     = i;
    bus.network_time = nt;
    bus.input_ack    = ack;
    psh = v && (mq.size() < 16);
    if (m_pres) begin
      if (ack) begin
        void'(mq.pop_front());
        m_pres = 1'b0;
      end
    end else if (mq.size() > 0) begin
      d = nt - mq[0].t;
      if (d < 16'h8000) begin
        m_pres = 1'b1;
        m_idx  = mq[0].i;
        if (d != 0 && m_late != 16'hFFFF) m_late = m_late + 16'd1;
      end
    end
    if (psh) begin
      e.t = t;
      e.i = i;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] nt;
    logic [15:0] t_last;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.ev_valid = 1'b0;
    bus.ev_time = '0;
    bus.ev_index = '0;
    bus.network_time = 16'd3;
    bus.input_ack = 1'b0;
    model_reset();

    //        v  t      i        nt     ack  eo eidx     cnt late rdy
    tbl[0] = '{1, 16'd5, 14'h123, 16'd3, 0,  0, 14'h000, 1,  0,   1};
    tbl[1] = '{0, 16'd0, 14'h000, 16'd3, 0,  0, 14'h000, 1,  0,   1};
    tbl[2] = '{0, 16'd0, 14'h000, 16'd4, 0,  0, 14'h000, 1,  0,   1};
    tbl[3] = '{0, 16'd0, 14'h000, 16'd5, 0,  1, 14'h123, 1,  0,   1};
    tbl[4] = '{0, 16'd0, 14'h000, 16'd6, 1,  0, 14'h123, 0,  0,   1};
    tbl[5] = '{0, 16'd0, 14'h000, 16'd6, 1,  0, 14'h123, 0,  0,   1};
    tbl[6] = '{0, 16'd0, 14'h000, 16'd7, 0,  0, 14'h123, 0,  0,   1};

    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 0, 14'h0, 0, 0, 1);
    reset = 1'b0;
    #1;
    check_all("reset_state", 0, 14'h0, 0, 0, 1);

    // Basic release from the vector table
    for (int k = 0; k < 7; k++) begin
      step(tbl[k].v, tbl[k].t, tbl[k].i, tbl[k].nt, tbl[k].ack);
      check_all($sformatf("basic[%0d]", k), tbl[k].eo, tbl[k].eidx,
                tbl[k].ecnt, tbl[k].elate, tbl[k].erdy);
    end

    // Late burst acked in the first presenting cycle
    step(1, 16'd2, 14'h10, 16'd7, 0); check_all("late_a", 0, 14'h123, 1, 0, 1);
    step(1, 16'd2, 14'h11, 16'd7, 0); check_all("late_b", 1, 14'h010, 2, 1, 1);
    step(1, 16'd2, 14'h12, 16'd7, 1); check_all("late_c", 0, 14'h010, 2, 1, 1);
    step(0, 16'd0, 14'h0,  16'd7, 0); check_all("late_d", 1, 14'h011, 2, 2, 1);
    step(0, 16'd0, 14'h0,  16'd7, 1); check_all("late_e", 0, 14'h011, 1, 2, 1);
    step(0, 16'd0, 14'h0,  16'd7, 0); check_all("late_f", 1, 14'h012, 1, 3, 1);
    step(0, 16'd0, 14'h0,  16'd7, 1); check_all("late_g", 0, 14'h012, 0, 3, 1);
    step(0, 16'd0, 14'h0,  16'd7, 0); check_all("late_h", 0, 14'h012, 0, 3, 1);

    // Backpressure: fill 16, hold off the 17th, release one slot
    for (int k = 0; k < 16; k++) begin
      step(1, 16'h100, 14'(k), 16'h0, 0);
      check_all($sformatf("bp_fill[%0d]", k), 0, 14'h012, k + 1, 3, k < 15);
    end
    step(1, 16'h100, 14'd16, 16'h0,   0); check_all("bp_held",  0, 14'h012, 16, 3, 0);
    step(1, 16'h100, 14'd16, 16'h100, 0); check_all("bp_pres",  1, 14'h000, 16, 3, 0);
    step(1, 16'h100, 14'd16, 16'h100, 1); check_all("bp_pop",   0, 14'h000, 15, 3, 1);
    step(1, 16'h100, 14'd16, 16'h100, 0); check_all("bp_accept", 1, 14'h001, 16, 3, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 16'h0, 14'h0, 16'h100, 1);
      check_all($sformatf("bp_ack[%0d]", k), 0, 14'(k), 16 - k, 3, 1);
      if (k < 16) begin
        step(0, 16'h0, 14'h0, 16'h100, 0);
        check_all($sformatf("bp_next[%0d]", k), 1, 14'(k + 1), 16 - k, 3, 1);
      end
    end

    // Wrap-around of network time, then a held request
    step(1, 16'h0002, 14'h55, 16'hFFFE, 0); check_all("wrap_push", 0, 14'h010, 1, 3, 1);
    step(0, 16'h0, 14'h0, 16'hFFFE, 0); check_all("wrap_fffe", 0, 14'h010, 1, 3, 1);
    step(0, 16'h0, 14'h0, 16'hFFFF, 0); check_all("wrap_ffff", 0, 14'h010, 1, 3, 1);
    step(0, 16'h0, 14'h0, 16'h0000, 0); check_all("wrap_0000", 0, 14'h010, 1, 3, 1);
    step(0, 16'h0, 14'h0, 16'h0001, 0); check_all("wrap_0001", 0, 14'h010, 1, 3, 1);
    step(0, 16'h0, 14'h0, 16'h0002, 0); check_all("wrap_due",  1, 14'h055, 1, 3, 1);
    for (int k = 0; k < 10; k++) begin
      step(0, 16'h0, 14'h0, 16'(3 + k), 0);
      check_all($sformatf("hold[%0d]", k), 1, 14'h055, 1, 3, 1);
    end
    step(0, 16'h0, 14'h0, 16'd13, 1); check_all("hold_ack", 0, 14'h055, 0, 3, 1);

    // Reset while presenting with four events queued
    for (int k = 0; k < 4; k++) begin
      step(1, 16'd20, 14'(16'h200 + k), 16'd20, 0);
      check_all($sformatf("rst_fill[%0d]", k), k > 0, (k > 0) ? 14'h200 : 14'h055, k + 1, 3, 1);
    end
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid", 0, 14'h0, 0, 0, 1);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0, 16'd0, 14'h0, 16'd20, 0);
      check_all($sformatf("rst_after[%0d]", k), 0, 14'h0, 0, 0, 1);
    end

    // Randomized traffic against the reference model, crossing the time wrap
    nt = 16'hFF00;
    t_last = nt - 16'd4;
    for (int c = 0; c < 3000; c++) begin
      bit          v;
      bit          ack;
      logic [13:0] idx;
      v   = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 2) != 0);
      idx = 14'($urandom);
      if ($urandom_range(0, 1) == 1) nt = nt + 16'd1;
      if (v && mq.size() < 16) t_last = t_last + 16'($urandom_range(0, 3));
      step(v, t_last, idx, nt, ack);
      check_model($sformatf("rand[%0d]", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_event_scheduler.md
# input_event_scheduler

Timestamped input-spike queue directly upstream of `network_processor`. Host logic pushes (time, synapse-row index) events in nondecreasing time order. The block buffers them in a register FIFO and, when the head event's time is reached by `network_time`, drives `input_occurred`/`input_index` into the processor. It holds the request until the processor returns `input_ack`.

## Interface
Parameters:
- `SR_DEPTH`, 16384: synapse rows; index width `IW = $clog2(SR_DEPTH)` (14).
- `MAX_NETWORK_TIME`, 65536: time modulus; time width `TW = $clog2(MAX_NETWORK_TIME)` (16).
- `FIFO_DEPTH`, 16: event entries; power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `ev_valid`  in  1: host event valid.
- `ev_ready`  out  1: FIFO can accept; `= (fifo_count != FIFO_DEPTH)`.
- `ev_time`  in  TW: scheduled network time of event.
- `ev_index`  in  IW: synapse row index to inject.
- `network_time`  in  TW: current time from `network_processor`.
- `input_occurred`  out  1: request to processor (registered).
- `input_index`  out  IW: row index of presented event (registered).
- `input_ack`  in  1: processor accepted presented event.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`: occupancy.
- `late_count`  out  16: saturating count of events presented after their time.

## Operation
- Push: `ev_valid & ev_ready` at a rising edge writes {`ev_time`, `ev_index`} at the write pointer. Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- No push when full, even if a pop occurs in the same cycle. `ev_ready` depends only on the registered count.
- Due test: `d = network_time - head_time` (mod 2^TW). The head is due when the FIFO is non-empty and `d[TW-1] == 0`, i.e. the head time is at most 2^(TW-1)-1 ticks in the past. This makes comparison correct across the 65535→0 wrap.
- FSM, 2 states:
  - `IDLE`: `input_occurred=0`. If the head is due, load `input_index <= head_index` and go to `PRESENT`. If also `d != 0`, increment `late_count` (saturating at 0xFFFF).
  - `PRESENT`: `input_occurred=1`; `input_index` stable. On `input_ack`, pop the head and go to `IDLE` (`input_occurred` falls next edge). Without ack, stay in `PRESENT` indefinitely.
- `input_ack` in `IDLE` is ignored.
- The head entry is never popped without an ack. Push and pop in the same cycle leaves `fifo_count` unchanged.
- Ordering: the host guarantees nondecreasing `ev_time`. Out-of-order events are still released strictly in FIFO order; the block does not reorder them.
- `network_time` may advance while in `PRESENT`. This has no effect on the presented event.

## Timing
- Reset (async assert, sync deassert by system):
  - `input_occurred=0`, `input_index=0`, `fifo_count=0`, `late_count=0`.
  - State `IDLE`, pointers 0, so `ev_ready=1`.
  - FIFO contents are don't-care.
- Push at edge t into an empty FIFO with a due time gives `input_occurred=1` after edge t+1. Latency is 2 cycles from the push handshake.
- A head becoming due (`network_time` changes at edge t) gives `input_occurred=1` after edge t+1.
- Ack sampled at edge k while `PRESENT`:
  - Pop occurs at k; `input_occurred=0` after k.
  - The next due event raises it after k+1.
  - Minimum one idle cycle between requests; peak throughput is 1 event per 2 cycles.
- Ack may arrive in the first `PRESENT` cycle.
- Reset asserted mid-`PRESENT` drops `input_occurred` immediately and discards the event and all queued events.

## Test plan
- Basic release: push (time=5, idx=0x0123) with `network_time=3`. Expect `input_occurred` low until `network_time=5`, high one cycle later with `input_index=0x0123`. Ack → low next cycle; `fifo_count` 1→0; `late_count=0`.
- Late event and burst: push (2,0x10), (2,0x11), (2,0x12) at `network_time=7`, acking each in the first `PRESENT` cycle. Expect 3 requests in order, each 1 cycle wide, each separated by exactly 1 low cycle; `late_count=3`.
- Backpressure: with `network_time` behind all events, push 17 events. Expect `ev_ready=0` after the 16th; the 17th is held off; `fifo_count=16`. One ack'd pop raises `ev_ready`, and the 17th is accepted.
- Wrap-around: push (time=0x0002) at `network_time=0xFFFE`. Not due at 0xFFFE or 0xFFFF; presented after `network_time=0x0002`; `late_count` unchanged.
- Held request: withhold ack 10 cycles while `network_time` advances. Expect `input_occurred` and `input_index` stable and no pop; ack → pop.
- Reset mid-operation: assert `reset` during `PRESENT` with 4 queued events. Expect immediate `input_occurred=0`, `fifo_count=0`, `late_count=0`, `ev_ready=1`. After release, no request until new pushes arrive.
